// File: rtl/stack_rev_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | stack_rev_pkg : shared types and sizing helper for burst reverser |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
package stack_rev_pkg;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } rev_state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_burst_reverser_lifo.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lifo : register-file stack, top of stack presented on popData     |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module lifo
    import stack_rev_pkg::*;
#(
    parameter int bW = 8,
    parameter int eC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [bW-1:0] pushData,
    input  logic          pop,
    output logic [bW-1:0] popData,
    output logic          full,
    output logic          empty
);

    localparam int CW = cnt_w(eC);
    localparam int AW = (eC > 1) ? $clog2(eC) : 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(eC);
    localparam logic [CW-1:0] C_ZERO  = '0;
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [bW-1:0] r_mem [eC];
    logic [CW-1:0] r_ptr;
    logic [CW-1:0] w_top;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_top    = r_ptr - C_ONE;
    assign w_wr_idx = AW'(r_ptr);
    assign w_rd_idx = AW'(w_top);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= C_ZERO;
        end else if (push && !full) begin
            r_ptr <= r_ptr + C_ONE;
        end else if (pop && !empty) begin
            r_ptr <= w_top;
        end
    end

    // Storage needs no reset: a word is only ever read after it was pushed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= pushData;
        end
    end

    assign popData = r_mem[w_rd_idx];
    assign full    = (r_ptr == C_DEPTH);
    assign empty   = (r_ptr == C_ZERO);

endmodule
`default_nettype wire

// File: rtl/stack_burst_reverser.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | stack_burst_reverser : stacks each input burst (or eC-word chunk) |
// | and replays it in reverse order. Revision 1.0                     |
// +-------------------------------------------------------------------+
module stack_burst_reverser
    import stack_rev_pkg::*;
#(
    parameter int bW = 8,
    parameter int eC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [bW-1:0] inData,
    input  logic          inValid,
    input  logic          inLast,
    output logic          inReady,
    output logic [bW-1:0] outData,
    output logic          outValid,
    output logic          outLast,
    input  logic          outReady,
    output logic          split
);

    localparam int CW = cnt_w(eC);
    localparam logic [CW-1:0] C_DEPTH = CW'(eC);
    localparam logic [CW-1:0] C_LAST  = CW'(eC - 1);
    localparam logic [CW-1:0] C_ZERO  = '0;
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    rev_state_t    r_state;
    rev_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_out_last;
    logic          w_split;
    logic [bW-1:0] w_pop_data;
    logic          w_full;
    logic          w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_push      = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_pop       = 1'b0;
        w_split     = 1'b0;
        case (r_state)
            S_FILL: begin
                w_in_ready = (r_cnt < C_DEPTH);
                w_push     = inValid & w_in_ready;
                if (w_push) begin
                    if (inLast) begin
                        w_state_nxt = S_DRAIN;
                    end else if (r_cnt == C_LAST) begin
                        // Stack is about to fill: close this chunk early.
                        w_state_nxt = S_DRAIN;
                        w_split     = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_out_valid = 1'b1;
                w_out_last  = (r_cnt == C_ONE);
                w_pop       = w_out_valid & outReady;
                if (w_pop && w_out_last) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
        // Reset is synchronous, so the registered state may still be stale
        // during the reset cycle; keep every handshake quiet regardless.
        if (rst) begin
            w_in_ready  = 1'b0;
            w_push      = 1'b0;
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_pop       = 1'b0;
            w_split     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= C_ZERO;
        end else if (w_push) begin
            r_cnt <= r_cnt + C_ONE;
        end else if (w_pop) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    lifo #(
        .bW (bW),
        .eC (eC)
    ) u_lifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pushData (inData),
        .pop      (w_pop),
        .popData  (w_pop_data),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign inReady  = w_in_ready;
    assign outValid = w_out_valid;
    assign outLast  = w_out_last;
    assign outData  = w_pop_data;
    assign split    = w_split;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_full == (r_cnt == C_DEPTH))
                else $error("lifo full flag disagrees with occupancy");
            assert (w_empty == (r_cnt == C_ZERO))
                else $error("lifo empty flag disagrees with occupancy");
            assert (!(w_push && w_pop))
                else $error("push and pop in the same cycle");
            assert ((r_state != S_DRAIN) || (r_cnt != C_ZERO))
                else $error("drain state with empty stack");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_burst_reverser.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_stack_burst_reverser : directed checks, bW=8 eC=4              |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module tb_stack_burst_reverser;

    localparam int C_BW = 8;
    localparam int C_EC = 4;

    logic            clk;
    logic            rst;
    logic [C_BW-1:0] inData;
    logic            inValid;
    logic            inLast;
    logic            inReady;
    logic [C_BW-1:0] outData;
    logic            outValid;
    logic            outLast;
    logic            outReady;
    logic            split;

    int errors = 0;
    int checks = 0;

    stack_burst_reverser #(
        .bW (C_BW),
        .eC (C_EC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inData   (inData),
        .inValid  (inValid),
        .inLast   (inLast),
        .inReady  (inReady),
        .outData  (outData),
        .outValid (outValid),
        .outLast  (outLast),
        .outReady (outReady),
        .split    (split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one input word, check it is accepted with the expected split flag.
    task automatic send(input logic [7:0] d, input logic last, input logic exp_split);
        inData  = d;
        inValid = 1'b1;
        inLast  = last;
        #1;
        chk($sformatf("in_ready@%0h", d), inReady, 1);
        chk($sformatf("split@%0h", d), split, exp_split);
        chk($sformatf("idle_out@%0h", d), outValid, 0);
        next_cycle();
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // Expect one output word with the given outReady; pops only when rdy=1.
    task automatic expect_out(input logic [7:0] d, input logic last, input logic rdy);
        outReady = rdy;
        #1;
        chk($sformatf("out_valid@%0h", d), outValid, 1);
        chk($sformatf("out_data@%0h", d), outData, d);
        chk($sformatf("out_last@%0h", d), outLast, last);
        chk($sformatf("drain_in_ready@%0h", d), inReady, 0);
        next_cycle();
        outReady = 1'b1;
    endtask

    task automatic expect_idle(input string tag);
        #1;
        chk({tag, "_in_ready"}, inReady, 1);
        chk({tag, "_out_valid"}, outValid, 0);
        chk({tag, "_out_last"}, outLast, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        inData   = '0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        next_cycle();
        #1;
        chk("rst_in_ready", inReady, 0);
        chk("rst_out_valid", outValid, 0);
        chk("rst_out_last", outLast, 0);
        chk("rst_split", split, 0);
        rst = 1'b0;
        next_cycle();
        expect_idle("post_rst");
        chk("post_rst_cnt", dut.r_cnt, 0);

        // 1: short burst reversed
        send(8'h11, 0, 0);
        send(8'h22, 0, 0);
        send(8'h33, 1, 0);
        expect_out(8'h33, 0, 1);
        expect_out(8'h22, 0, 1);
        expect_out(8'h11, 1, 1);
        expect_idle("t1_end");

        // 2: six-word burst split into 4 + 2
        send(8'hA0, 0, 0);
        send(8'hA1, 0, 0);
        send(8'hA2, 0, 0);
        send(8'hA3, 0, 1);
        expect_out(8'hA3, 0, 1);
        expect_out(8'hA2, 0, 1);
        expect_out(8'hA1, 0, 1);
        expect_out(8'hA0, 1, 1);
        expect_idle("t2_mid");
        send(8'hA4, 0, 0);
        send(8'hA5, 1, 0);
        expect_out(8'hA5, 0, 1);
        expect_out(8'hA4, 1, 1);
        expect_idle("t2_end");

        // 3: burst of exactly eC words, inLast wins over split
        send(8'h01, 0, 0);
        send(8'h02, 0, 0);
        send(8'h03, 0, 0);
        send(8'h04, 1, 0);
        expect_out(8'h04, 0, 1);
        expect_out(8'h03, 0, 1);
        expect_out(8'h02, 0, 1);
        expect_out(8'h01, 1, 1);
        expect_idle("t3_end");

        // 4: backpressure 1,0,0,1,1
        send(8'h31, 0, 0);
        send(8'h32, 0, 0);
        send(8'h33, 1, 0);
        expect_out(8'h33, 0, 1);
        expect_out(8'h32, 0, 0);
        expect_out(8'h32, 0, 0);
        chk("t4_stall_cnt", dut.r_cnt, 2);
        expect_out(8'h32, 0, 1);
        expect_out(8'h31, 1, 1);
        expect_idle("t4_end");

        // 5: single-word burst
        send(8'h5A, 1, 0);
        expect_out(8'h5A, 1, 1);
        expect_idle("t5_end");

        // 6: reset after the first drain pop discards the chunk
        send(8'h61, 0, 0);
        send(8'h62, 0, 0);
        send(8'h63, 1, 0);
        expect_out(8'h63, 0, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", outValid, 0);
        chk("t6_rst_in_ready", inReady, 0);
        next_cycle();
        rst = 1'b0;
        expect_idle("t6_after_rst");
        chk("t6_cnt", dut.r_cnt, 0);
        send(8'h77, 1, 0);
        expect_out(8'h77, 1, 1);
        expect_idle("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
